// File: rtl/nn_move_commit.sv
// rtl/nn_move_commit.sv - resolves a column move to a board RAM write; optional MOVE_COMMIT_FALLBACK_EN column search
module nn_move_commit #(
    parameter int ROWS          = 6,
    parameter int COLS          = 7,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BASE_ADDR     = 0,
    parameter int AI_CODE       = 2,
    parameter int HUMAN_CODE    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_game,
    input  logic                     move_valid,
    input  logic [2:0]               move_col,
    input  logic                     move_is_ai,
    output logic                     busy,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     done,
    output logic                     error,
    output logic [2:0]               placed_row,
    output logic [2:0]               placed_col,
    output logic [5:0]               move_count,
    output logic                     board_full
);

    localparam int HW = $clog2(ROWS + 1);
    localparam logic [HW-1:0]            ROWS_H   = HW'(ROWS);
    localparam logic [2:0]               COLS_C   = 3'(COLS);
    localparam logic [2:0]               LAST_COL = 3'(COLS - 1);
    localparam logic [5:0]               TOTAL    = 6'(ROWS * COLS);
    localparam logic [ADDRESS_WIDTH-1:0] BASE_A   = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] COLS_A   = ADDRESS_WIDTH'(COLS);
    localparam logic [DATA_WIDTH-1:0]    AI_D     = DATA_WIDTH'(AI_CODE);
    localparam logic [DATA_WIDTH-1:0]    HUMAN_D  = DATA_WIDTH'(HUMAN_CODE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
`ifdef MOVE_COMMIT_FALLBACK_EN
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] LAST_PROBE = 3'(COLS - 2);
`endif
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state;
    logic [2:0]    cur_col;
    logic          cur_ai;
    logic          reject;
    logic [HW-1:0] heights [COLS];
    logic [HW-1:0] cur_height;
    logic          col_open;
    logic [2:0]    next_col;
`ifdef MOVE_COMMIT_FALLBACK_EN
    logic [2:0]    probe_cnt;
`endif

    // Out-of-range columns read as full so they can never be selected.
    always_comb begin
        cur_height = ROWS_H;
        if (cur_col < COLS_C) begin
            cur_height = heights[cur_col];
        end
        col_open = (cur_height < ROWS_H);
        next_col = (cur_col == LAST_COL) ? 3'd0 : cur_col + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state      <= S_IDLE;
            cur_col    <= '0;
            cur_ai     <= 1'b0;
            reject     <= 1'b0;
            move_count <= '0;
            board_full <= 1'b0;
            placed_row <= '0;
            placed_col <= '0;
            for (int i = 0; i < COLS; i++) begin
                heights[i] <= '0;
            end
`ifdef MOVE_COMMIT_FALLBACK_EN
            probe_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (move_valid) begin
                        cur_col <= move_col;
                        cur_ai  <= move_is_ai;
                        reject  <= 1'b0;
                        state   <= S_CHECK;
                    end
                end
                // Rejected moves still pass through WRITE (strobe suppressed)
                // so done and error share the same latency.
                S_CHECK: begin
                    state <= S_WRITE;
                    if (cur_col >= COLS_C || board_full) begin
                        reject <= 1'b1;
                    end else if (!col_open) begin
`ifdef MOVE_COMMIT_FALLBACK_EN
                        cur_col   <= next_col;
                        probe_cnt <= '0;
                        state     <= S_SEARCH;
`else
                        reject    <= 1'b1;
`endif
                    end
                end
`ifdef MOVE_COMMIT_FALLBACK_EN
                S_SEARCH: begin
                    if (col_open) begin
                        state <= S_WRITE;
                    end else if (probe_cnt == LAST_PROBE) begin
                        reject <= 1'b1;
                        state  <= S_WRITE;
                    end else begin
                        cur_col   <= next_col;
                        probe_cnt <= probe_cnt + 3'd1;
                    end
                end
`endif
                S_WRITE: begin
                    if (!reject) begin
                        if (col_open) begin
                            heights[cur_col] <= cur_height + 1'b1;
                        end
                        if (move_count < TOTAL) begin
                            move_count <= move_count + 6'd1;
                        end
                        board_full <= (move_count >= TOTAL - 6'd1);
                        placed_row <= 3'(cur_height);
                        placed_col <= cur_col;
                    end
                    state <= S_FINISH;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        mem_we    = (state == S_WRITE) && !reject;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we) begin
            mem_addr  = BASE_A + ADDRESS_WIDTH'(cur_height) * COLS_A + ADDRESS_WIDTH'(cur_col);
            mem_wdata = cur_ai ? AI_D : HUMAN_D;
        end
        done  = (state == S_FINISH) && !reject;
        error = (state == S_FINISH) && reject;
    end

endmodule
